// File: rtl/series_ctrl.sv
// Sequencing FSM for the Q8.8 series-evaluation datapath: init, N_TERMS multiply/accumulate
// iterations, term-counter flush back to zero, then a done pulse with the latched compare flag.
module series_ctrl #(
  parameter int N_TERMS   = 16,
  parameter bit ALTERNATE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic gt,
  input  logic lsb_counter,
  output logic counter_en,
  output logic sel_1,
  output logic sel_2,
  output logic sel_x,
  output logic sel_t,
  output logic load_x,
  output logic load_m,
  output logic load_t,
  output logic mode,
  output logic busy,
  output logic done,
  output logic result_gt
);

  typedef enum logic [2:0] {
    IDLE, INIT, FIRST, ACC, MULX, MULC, FLUSH, DONE
  } state_t;

  localparam logic [3:0] LAST_TERM  = 4'(N_TERMS - 1);
  // The flush pads the datapath counter from N_TERMS up to its wrap at 16.
  localparam logic [3:0] LAST_FLUSH = 4'(15 - N_TERMS);
  localparam bit         HAS_FLUSH  = (N_TERMS < 16);

  state_t     state, next_state;
  logic [3:0] term_cnt;
  logic [3:0] flush_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      term_cnt  <= '0;
      flush_cnt <= '0;
      result_gt <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ACC)
        term_cnt <= term_cnt + 4'd1;
      if (state == FLUSH)
        flush_cnt <= (flush_cnt == LAST_FLUSH) ? 4'd0 : flush_cnt + 4'd1;
      if (state == DONE) begin
        term_cnt  <= '0;
        result_gt <= gt;
      end
    end
  end

  // NOTE: every output and next_state gets a default before the case, so no
  // path through this block can infer a latch.
  always_comb begin
    next_state = state;
    counter_en = 1'b0;
    sel_1      = 1'b0;
    sel_2      = 1'b0;
    sel_x      = 1'b0;
    sel_t      = 1'b0;
    load_x     = 1'b0;
    load_m     = 1'b0;
    load_t     = 1'b0;
    mode       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) next_state = INIT;
      INIT: begin
        busy       = 1'b1;
        load_x     = 1'b1;
        load_t     = 1'b1;
        next_state = FIRST;
      end
      FIRST: begin
        busy       = 1'b1;
        sel_2      = 1'b1;
        load_m     = 1'b1;
        next_state = ACC;
      end
      ACC: begin
        busy       = 1'b1;
        sel_t      = 1'b1;
        load_t     = 1'b1;
        counter_en = 1'b1;
        mode       = ALTERNATE & lsb_counter;
        if (term_cnt == LAST_TERM)
          next_state = HAS_FLUSH ? FLUSH : DONE;
        else
          next_state = MULX;
      end
      MULX: begin
        busy       = 1'b1;
        sel_1      = 1'b1;
        load_m     = 1'b1;
        next_state = MULC;
      end
      MULC: begin
        busy       = 1'b1;
        sel_1      = 1'b1;
        sel_2      = 1'b1;
        load_m     = 1'b1;
        next_state = ACC;
      end
      FLUSH: begin
        busy       = 1'b1;
        counter_en = 1'b1;
        if (flush_cnt == LAST_FLUSH) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_series_ctrl.sv
// Directed bench for series_ctrl: a 16-term alternating instance and a 4-term non-alternating
// instance run side by side, each driving a small model of the datapath term counter.
module tb_series_ctrl;

  logic clk, rst, start, gt;
  logic a_ce, a_s1, a_s2, a_sx, a_st, a_lx, a_lm, a_lt, a_mode, a_busy, a_done, a_rgt;
  logic b_ce, b_s1, b_s2, b_sx, b_st, b_lx, b_lm, b_lt, b_mode, b_busy, b_done, b_rgt;
  logic [3:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  series_ctrl #(.N_TERMS(16), .ALTERNATE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lsb_counter(cnt_a[0]),
    .counter_en(a_ce), .sel_1(a_s1), .sel_2(a_s2), .sel_x(a_sx), .sel_t(a_st),
    .load_x(a_lx), .load_m(a_lm), .load_t(a_lt), .mode(a_mode), .busy(a_busy),
    .done(a_done), .result_gt(a_rgt)
  );

  series_ctrl #(.N_TERMS(4), .ALTERNATE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lsb_counter(cnt_b[0]),
    .counter_en(b_ce), .sel_1(b_s1), .sel_2(b_s2), .sel_x(b_sx), .sel_t(b_st),
    .load_x(b_lx), .load_m(b_lm), .load_t(b_lt), .mode(b_mode), .busy(b_busy),
    .done(b_done), .result_gt(b_rgt)
  );

  // Datapath term counters, advanced by counter_en and cleared by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ce) cnt_a <= cnt_a + 4'd1;
      if (b_ce) cnt_b <= cnt_b + 4'd1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: counter_en sel_1 sel_2 sel_x sel_t load_x load_m load_t mode busy done
  localparam logic [10:0] W_IDLE  = 11'b00000000000;
  localparam logic [10:0] W_INIT  = 11'b00000101010;
  localparam logic [10:0] W_FIRST = 11'b00100010010;
  localparam logic [10:0] W_ACC   = 11'b10001001010;
  localparam logic [10:0] W_MULX  = 11'b01000010010;
  localparam logic [10:0] W_MULC  = 11'b01100010010;
  localparam logic [10:0] W_FLUSH = 11'b10000000010;
  localparam logic [10:0] W_DONE  = 11'b00000000001;

  typedef struct {
    logic [10:0] ctrl;
    int          reps;
  } vec_t;

  vec_t       tbl[$];
  logic [10:0] exp_b[$];

  function automatic logic [10:0] word_a();
    return {a_ce, a_s1, a_s2, a_sx, a_st, a_lx, a_lm, a_lt, a_mode, a_busy, a_done};
  endfunction

  function automatic logic [10:0] word_b();
    return {b_ce, b_s1, b_s2, b_sx, b_st, b_lx, b_lm, b_lt, b_mode, b_busy, b_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run from a start pulse (or a held start); cycle 1 is the INIT cycle.
  task automatic run(input bit hold, input bit full_checks);
    int done_a1, done_b1, done_b2, ce_a, ce_b, busy_a, busy_b, acc_idx, overlap;
    logic busy_b26, busy_b27;
    done_a1 = -1; done_b1 = -1; done_b2 = -1;
    ce_a = 0; ce_b = 0; busy_a = 0; busy_b = 0; acc_idx = 0; overlap = 0;
    busy_b26 = 1'b1; busy_b27 = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      tick();
      if (!hold) start = 1'b0;
      gt = (c < 30);
      if (a_done && done_a1 < 0) done_a1 = c;
      if (b_done) begin
        if (done_b1 < 0) done_b1 = c;
        else if (done_b2 < 0) done_b2 = c;
      end
      if (a_ce) ce_a++;
      if (b_ce) ce_b++;
      if (a_busy) busy_a++;
      if (b_busy) busy_b++;
      if ((a_lm && a_lt) || (b_lm && b_lt)) overlap++;
      if (c == 26) busy_b26 = b_busy;
      if (c == 27) busy_b27 = b_busy;
      if (full_checks) begin
        if (c <= exp_b.size())
          check($sformatf("b_ctrl_c%0d", c), 32'(word_b()), 32'(exp_b[c-1]));
        if (a_ce && a_lt) begin
          check($sformatf("a_mode_acc%0d", acc_idx), 32'(a_mode), 32'(acc_idx % 2));
          acc_idx++;
        end
      end
    end
    start = 1'b0;
    check("a_done_cycle", 32'(done_a1), 32'd49);
    check("b_done_cycle", 32'(done_b1), 32'd25);
    if (full_checks) begin
      check("a_busy_len", 32'(busy_a), 32'd48);
      check("b_busy_len", 32'(busy_b), 32'd24);
      check("a_ce_pulses", 32'(ce_a), 32'd16);
      check("b_ce_pulses", 32'(ce_b), 32'd16);
      check("a_acc_count", 32'(acc_idx), 32'd16);
      check("a_cnt_final", 32'(cnt_a), 32'd0);
      check("b_cnt_final", 32'(cnt_b), 32'd0);
      check("a_result_gt", 32'(a_rgt), 32'd0);
      check("b_result_gt", 32'(b_rgt), 32'd1);
      check("b_no_second_run", 32'(done_b2), 32'hFFFF_FFFF);
    end else begin
      check("b_idle_after_done", 32'(busy_b26), 32'd0);
      check("b_restart_busy", 32'(busy_b27), 32'd1);
      check("b_second_done", 32'(done_b2), 32'd51);
    end
    check("ld_m_ld_t_overlap", 32'(overlap), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int late_done;
    rst = 1'b1; start = 1'b0; gt = 1'b1;

    // Expected control sequence of the 4-term instance.
    tbl.push_back('{W_INIT, 1});
    tbl.push_back('{W_FIRST, 1});
    tbl.push_back('{W_ACC, 1});
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{W_MULX, 1});
      tbl.push_back('{W_MULC, 1});
      tbl.push_back('{W_ACC, 1});
    end
    tbl.push_back('{W_FLUSH, 12});
    tbl.push_back('{W_DONE, 1});
    tbl.push_back('{W_IDLE, 2});
    foreach (tbl[i])
      for (int r = 0; r < tbl[i].reps; r++) exp_b.push_back(tbl[i].ctrl);

    tick();
    check("rst_a_ctrl", 32'(word_a()), 32'd0);
    check("rst_b_ctrl", 32'(word_b()), 32'd0);
    check("rst_a_result_gt", 32'(a_rgt), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_b_ctrl", 32'(word_b()), 32'd0);

    // Single pulsed run: timing, control sequence, modes, counters, result flags.
    run(1'b0, 1'b1);

    // Start held high throughout: one run each, then immediate restart.
    do_reset();
    run(1'b1, 1'b0);

    // Reset in cycle 10 of a run.
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_a_ctrl", 32'(word_a()), 32'd0);
    check("midrst_b_ctrl", 32'(word_b()), 32'd0);
    check("midrst_b_result_gt", 32'(b_rgt), 32'd0);
    #2 rst = 1'b0;
    late_done = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (a_done || b_done || a_busy || b_busy) late_done++;
    end
    check("midrst_no_activity", 32'(late_done), 32'd0);

    // Fresh run after the aborted one.
    run(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
